// File: rtl/rgbw_frame_decoder.sv
// ----------------------------------------------------------------------------
// rgbw_frame_decoder
//
// Parses SPI chip-select frames coming out of the byte receiver into RGBW
// intensities. Each frame is one command byte followed by channel data bytes.
// Data bytes land in shadow registers. The shadows are copied to the outputs
// in one step at frame end, or immediately on a COMMIT or CLEAR command, so
// the PWM stage never sees a partly updated colour.
//
// Command byte: [7:6] opcode (00 WRITE, 01 COMMIT, 10 CLEAR, 11 invalid),
//               [5:2] ignored, [1:0] start channel for WRITE.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cs         raw SPI chip select, active low, asynchronous to clk
//   rdy        byte-ready from the SPI slave (may be held high)
//   data       received byte, valid while rdy is high
//   red/green/blue/white  committed 8-bit intensities
//   update     one-clk pulse whenever the outputs are written
//   frame_err  sticky flag: set by an invalid opcode, cleared by a WRITE
// ----------------------------------------------------------------------------
module rgbw_frame_decoder #(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] RST_LEVEL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rdy,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] white,
    output logic       update,
    output logic       frame_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_IGNORE = 2'd3;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    logic       r_cs_meta;
    logic       r_cs_sync;
    logic       r_cs_sync_q;
    logic       r_rdy_q;
    logic [1:0] r_state;
    logic [1:0] r_ptr;
    logic       r_wr_seen;
    logic       r_update;
    logic       r_frame_err;
    logic [7:0] r_shadow [NUM_CH];
    logic [7:0] r_out    [NUM_CH];

    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_strobe;
    logic [1:0] w_state_nxt;
    logic [1:0] w_ptr_nxt;
    logic       w_wr_seen_nxt;
    logic       w_err_nxt;
    logic       w_load;
    logic [7:0] w_shadow_nxt [NUM_CH];

    // Edge detection on the synchronised chip select only; the raw pad
    // signal is never looked at directly.
    assign w_cs_fall = r_cs_sync_q & ~r_cs_sync;
    assign w_cs_rise = ~r_cs_sync_q & r_cs_sync;

    // A held-high rdy yields a single strobe on its rising edge.
    assign w_strobe  = rdy & ~r_rdy_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wr_seen_nxt = r_wr_seen;
        w_err_nxt     = r_frame_err;
        w_shadow_nxt  = r_shadow;
        w_load        = 1'b0;

        if (w_cs_fall) begin
            // A new frame (or a cs glitch) always restarts at the command
            // byte; shadows already written stay but are not committed.
            w_state_nxt   = ST_CMD;
            w_ptr_nxt     = 2'd0;
            w_wr_seen_nxt = 1'b0;
        end else begin
            if (w_strobe) begin
                case (r_state)
                    ST_CMD: begin
                        w_state_nxt = ST_IGNORE;
                        case (data[7:6])
                            OP_WRITE: begin
                                w_state_nxt = ST_DATA;
                                w_ptr_nxt   = data[1:0];
                                w_err_nxt   = 1'b0;
                            end
                            OP_COMMIT: w_load = 1'b1;
                            OP_CLEAR: begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    w_shadow_nxt[i] = RST_LEVEL;
                                end
                                w_load = 1'b1;
                            end
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                    ST_DATA: begin
                        // Pointer wraps 3->0; extra bytes overwrite earlier
                        // channels by design.
                        w_shadow_nxt[r_ptr] = data;
                        w_ptr_nxt           = r_ptr + 2'd1;
                        w_wr_seen_nxt       = 1'b1;
                    end
                    default: ;
                endcase
            end

            // The byte above is folded in first, so a strobe landing in the
            // same cycle as the cs rise is part of this commit.
            if (w_cs_rise) begin
                if ((r_state == ST_DATA) && w_wr_seen_nxt) begin
                    w_load = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // cs is idle-high, so the synchroniser presets to 1 and reset
            // cannot fabricate a falling edge.
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_sync_q <= 1'b1;
            r_rdy_q     <= 1'b0;
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_wr_seen   <= 1'b0;
            r_update    <= 1'b0;
            r_frame_err <= 1'b0;
            // NOTE: the shadow array is reset explicitly because a COMMIT
            // straight after reset must publish RST_LEVEL, not garbage.
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= RST_LEVEL;
                r_out[i]    <= RST_LEVEL;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples values from before this edge.
            r_cs_meta   <= cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_sync_q <= r_cs_sync;
            r_rdy_q     <= rdy;
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_wr_seen   <= w_wr_seen_nxt;
            r_frame_err <= w_err_nxt;
            r_shadow    <= w_shadow_nxt;
            r_update    <= w_load;
            if (w_load) begin
                r_out <= w_shadow_nxt;
            end
        end
    end

    assign red       = r_out[0];
    assign green     = r_out[1];
    assign blue      = r_out[2];
    assign white     = r_out[3];
    assign update    = r_update;
    assign frame_err = r_frame_err;

endmodule

// File: doc/rgbw_frame_decoder.md
Name: rgbw_frame_decoder

Overview:
Sits directly downstream of the SPI slave byte receiver. It consumes the receiver's ready strobe and data byte, parses each chip-select frame as one command byte followed by channel data bytes, and holds the parsed values in shadow registers. At frame end it commits the shadow registers atomically to the R/G/B/W intensity outputs that feed the PWM stage.

Parameters:
NUM_CH, 4, number of channels (fixed order R=0, G=1, B=2, W=3); index width is 2 bits.
RST_LEVEL, 8'h00, value loaded into shadow and output registers on reset and on CLEAR.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
cs  input  1  raw SPI chip select from the pad, active-low (high = idle); asynchronous to clk.
rdy  input  1  byte-ready from the SPI slave; may stay high for more than one clk.
data  input  8  received byte; valid whenever rdy is high.
red  output  8  committed red intensity.
green  output  8  committed green intensity.
blue  output  8  committed blue intensity.
white  output  8  committed white intensity.
update  output  1  one-clk pulse when outputs change by commit or clear.
frame_err  output  1  sticky error flag.

Behaviour:
- Reset (reset=1 at a clk edge):
  - red/green/blue/white and all shadows = RST_LEVEL.
  - update=0, frame_err=0, state=IDLE, channel pointer=0, wr_seen=0.
  - cs synchroniser flops preset to 1.
- cs handling:
  - cs passes through a 2-flop synchroniser, then a rising/falling edge detector on the synced value.
  - All decisions use synced cs.
- rdy handling:
  - Byte strobe = rising edge of rdy (rdy registered once, strobe = rdy & ~rdy_q).
  - data is captured on the strobe cycle.
  - A held-high rdy produces exactly one strobe.
- Command byte format:
  - [7:6] opcode: 00 WRITE, 01 COMMIT, 10 CLEAR, 11 invalid.
  - [5:2] ignored.
  - [1:0] start channel.
- FSM:
  - IDLE: on synced cs falling -> CMD; pointer=0, wr_seen=0.
  - CMD, on strobe:
    - WRITE -> DATA; pointer=[1:0]; frame_err cleared.
    - COMMIT -> IGNORE; copy shadows to outputs next cycle, pulse update.
    - CLEAR -> IGNORE; shadows and outputs = RST_LEVEL, pulse update.
    - 11 -> IGNORE; set frame_err.
  - DATA, on strobe:
    - shadow[pointer] <= data; pointer <= pointer+1, wrapping 3->0; wr_seen=1.
    - More than 4 data bytes keep wrapping and overwrite earlier channels; this is not an error.
  - IGNORE: strobes are discarded.
  - Any state: on synced cs rising -> IDLE.
    - If the state was DATA and wr_seen=1, commit shadows to outputs and pulse update.
    - A frame with a WRITE command but zero data bytes commits nothing.
- Simultaneous events:
  - A strobe and a synced cs rise in the same cycle: the byte is processed first, then the commit includes that byte.
- Latency: commit outputs and update are valid 1 clk after the cycle that detects the synced cs rise or the COMMIT/CLEAR strobe.
- update: high for exactly one clk per commit/clear; never asserted without an output write.
- Channel isolation: outputs not written in a frame keep their previous committed values, since shadows persist across frames.
- cs falling while the FSM is not in IDLE (glitch) restarts at CMD; partial shadow writes already made are kept but not committed.
- reset mid-frame: everything returns to reset values; the next frame needs a fresh cs falling edge.

Test Plan:
- Reset -> all four outputs 8'h00, update=0, frame_err=0.
- Frame with cs low, bytes 0x00, 0x11, 0x22, 0x33, 0x44, then cs high -> red=11, green=22, blue=33, white=44 after cs rise plus sync and 1 clk; update pulses exactly once.
- Frame 0x03, 0xAA, 0xBB -> white=AA, red=BB (pointer wraps); green and blue unchanged; single update pulse.
- Frame 0xC0, 0x55 -> frame_err=1, no output change, no update; next frame 0x01, 0x77 -> green=77, frame_err=0.
- rdy held high 3 clks with data=0x99 in DATA state -> one shadow write only; last strobe coincident with synced cs rise -> that byte is included in the commit.
- Frame 0x00, 0x12 with reset=1 asserted before cs rises -> outputs 00, no update; frame 0x80 -> outputs stay 00 and update pulses once.
